// File: rtl/quad_nand_selftest_ctrl.sv
// Self-test sequencer for a quad 2-input NAND package: walks each enabled gate through its
// truth table, waits for settling, then reports error count and the first failing vector.
module quad_nand_selftest_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] gate_mask,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec,
    output logic       fail_valid
);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES);
    localparam logic [4:0] ErrMax     = 5'd16;

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

    state_e     r_state, w_state_d;
    logic [3:0] r_mask, w_mask_d;
    logic [3:0] r_idx, w_idx_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic [4:0] r_err, w_err_d;
    logic [3:0] r_fail_vec, w_fail_vec_d;
    logic       r_fail_valid, w_fail_valid_d;

    logic [1:0] w_gate;
    logic [3:0] w_sel;
    logic [3:0] w_exp_y;
    logic       w_mismatch;
    logic       w_first_ok, w_next_ok;
    logic [1:0] w_first_gate, w_next_gate;

    assign w_gate     = r_idx[3:2];
    assign w_sel      = 4'b0001 << w_gate;
    assign w_exp_y    = (r_idx[1] & r_idx[0]) ? ~w_sel : 4'b1111;
    assign w_mismatch = (Y != w_exp_y);

    // Descending scan leaves the lowest qualifying gate in the result.
    always_comb begin
        w_first_ok   = 1'b0;
        w_first_gate = 2'd0;
        w_next_ok    = 1'b0;
        w_next_gate  = 2'd0;
        for (int g = 3; g >= 0; g--) begin
            if (gate_mask[g]) begin
                w_first_ok   = 1'b1;
                w_first_gate = 2'(g);
            end
            if (r_mask[g] && (2'(g) > w_gate)) begin
                w_next_ok   = 1'b1;
                w_next_gate = 2'(g);
            end
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_mask_d       = r_mask;
        w_idx_d        = r_idx;
        w_cnt_d        = r_cnt;
        w_err_d        = r_err;
        w_fail_vec_d   = r_fail_vec;
        w_fail_valid_d = r_fail_valid;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_mask_d       = gate_mask;
                    w_err_d        = 5'd0;
                    w_fail_vec_d   = 4'd0;
                    w_fail_valid_d = 1'b0;
                    if (w_first_ok) begin
                        w_idx_d   = {w_first_gate, 2'b00};
                        w_state_d = StApply;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StApply: begin
                w_cnt_d   = SettleLoad;
                w_state_d = StSettle;
            end
            StSettle: begin
                if (r_cnt <= 8'd1) w_state_d = StCheck;
                else               w_cnt_d   = r_cnt - 8'd1;
            end
            StCheck: begin
                if (w_mismatch) begin
                    if (r_err != ErrMax) w_err_d = r_err + 5'd1;
                    if (!r_fail_valid) begin
                        w_fail_vec_d   = r_idx;
                        w_fail_valid_d = 1'b1;
                    end
                end
                if (r_idx[1:0] != 2'b11) begin
                    w_idx_d   = r_idx + 4'd1;
                    w_state_d = StApply;
                end else if (w_next_ok) begin
                    w_idx_d   = {w_next_gate, 2'b00};
                    w_state_d = StApply;
                end else begin
                    w_state_d = StDone;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_mask       <= 4'd0;
            r_idx        <= 4'd0;
            r_cnt        <= 8'd0;
            r_err        <= 5'd0;
            r_fail_vec   <= 4'd0;
            r_fail_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_mask       <= w_mask_d;
            r_idx        <= w_idx_d;
            r_cnt        <= w_cnt_d;
            r_err        <= w_err_d;
            r_fail_vec   <= w_fail_vec_d;
            r_fail_valid <= w_fail_valid_d;
        end
    end

    assign busy       = (r_state == StApply) || (r_state == StSettle) || (r_state == StCheck);
    assign done       = (r_state == StDone);
    assign pass       = done && (r_err == 5'd0);
    assign A          = (busy && r_idx[1]) ? w_sel : 4'b0000;
    assign B          = (busy && r_idx[0]) ? w_sel : 4'b0000;
    assign err_count  = r_err;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule
